// File: rtl/counter_share_ctrl.sv
// rtl/counter_share_ctrl.sv - one modulus counter shared by N requesters via round-robin arbitration
// The owner's limit is latched at grant; done pulses to the owner when the count reaches it.
module counter_share_ctrl #(
   parameter int N = 4,
   parameter int W = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] limit_in,
   output logic [N-1:0]   grant,
   output logic           busy,
   output logic [N-1:0]   done,
   output logic [W-1:0]   Q,
   output logic [IW-1:0]  cur_id
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_n;
   logic [IW-1:0] rr_ptr, rr_n;
   logic [W-1:0]  lim, lim_n;
   logic [N-1:0]  grant_n, done_n;
   logic          busy_n;
   logic [W-1:0]  q_n;
   logic [IW-1:0] cur_id_n;

   logic          win_found;
   logic [IW-1:0] win_id;
   logic [IW-1:0] next_id;

   // First requesting index at or after rr_ptr, wrapping modulo N.
   always_comb begin : arb
      int idx;
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_id    = IW'(idx);
         end
      end
   end

   assign next_id = (cur_id == IW'(N-1)) ? '0 : cur_id + 1'b1;

   always_comb begin
      state_n  = state;
      grant_n  = grant;
      busy_n   = busy;
      done_n   = '0;
      q_n      = Q;
      cur_id_n = cur_id;
      rr_n     = rr_ptr;
      lim_n    = lim;
      case (state)
         IDLE: begin
            grant_n = '0;
            busy_n  = 1'b0;
            q_n     = '0;
            if (win_found) begin
               state_n         = RUN;
               grant_n[win_id] = 1'b1;
               busy_n          = 1'b1;
               cur_id_n        = win_id;
               lim_n           = limit_in[win_id*W +: W];
            end
         end
         RUN: begin
            // Owner dropping its request aborts, even on the terminal count.
            if (!req[cur_id]) begin
               state_n = IDLE;
               grant_n = '0;
               busy_n  = 1'b0;
               q_n     = '0;
               rr_n    = next_id;
            end else if (Q == lim) begin
               state_n        = DONE;
               done_n[cur_id] = 1'b1;
               grant_n        = '0;
               busy_n         = 1'b0;
               q_n            = '0;
               rr_n           = next_id;
            end else begin
               q_n = Q + 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
            q_n     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         grant  <= '0;
         busy   <= 1'b0;
         done   <= '0;
         Q      <= '0;
         cur_id <= '0;
         rr_ptr <= '0;
         lim    <= '0;
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         busy   <= busy_n;
         done   <= done_n;
         Q      <= q_n;
         cur_id <= cur_id_n;
         rr_ptr <= rr_n;
         lim    <= lim_n;
      end
   end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// tb/tb_counter_share_ctrl.sv - directed-vector bench for counter_share_ctrl
// Observed bundle is {grant, busy, done, Q, cur_id}, sampled on the falling edge.
module tb_counter_share_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] limit_in = '0;
   logic [3:0]  grant;
   logic        busy;
   logic [3:0]  done;
   logic [3:0]  Q;
   logic [1:0]  cur_id;

   int vec_cnt = 0;
   int err_cnt = 0;

   wire [14:0] obs = {grant, busy, done, Q, cur_id};

   counter_share_ctrl #(.N(4), .W(4)) dut (
      .clk(clk), .reset(reset), .req(req), .limit_in(limit_in),
      .grant(grant), .busy(busy), .done(done), .Q(Q), .cur_id(cur_id)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] ex(input logic [3:0] g, input logic b,
                                      input logic [3:0] d, input logic [3:0] q,
                                      input logic [1:0] id);
      return {g, b, d, q, id};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req = '0;
      limit_in = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      vec_cnt++; if (obs !== 15'd0) begin err_cnt++; $display("FAIL reset_async got %h exp %h", obs, 15'd0); end
      do_reset();
      @(negedge clk);
      @(negedge clk);
      vec_cnt++; if (obs !== 15'd0) begin err_cnt++; $display("FAIL reset_idle got %h exp %h", obs, 15'd0); end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      limit_in[3:0] = 4'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vec_cnt++; if (obs !== ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)) begin err_cnt++; $display("FAIL single_run%0d got %h exp %h", i, obs, ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)); end
      end
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0001, 4'd0, 2'd0)) begin err_cnt++; $display("FAIL single_done got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0001, 4'd0, 2'd0)); end
      req = '0;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd0)) begin err_cnt++; $display("FAIL single_idle got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd0)); end
   endtask

   task automatic test_round_robin();
      logic [3:0] g;
      do_reset();
      limit_in = 16'h1111;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         g = 4'b0001 << (k % 4);
         @(negedge clk);
         vec_cnt++; if (obs !== ex(g, 1'b1, 4'b0, 4'd0, 2'(k % 4))) begin err_cnt++; $display("FAIL rr_grant%0d_q0 got %h exp %h", k, obs, ex(g, 1'b1, 4'b0, 4'd0, 2'(k % 4))); end
         @(negedge clk);
         vec_cnt++; if (obs !== ex(g, 1'b1, 4'b0, 4'd1, 2'(k % 4))) begin err_cnt++; $display("FAIL rr_grant%0d_q1 got %h exp %h", k, obs, ex(g, 1'b1, 4'b0, 4'd1, 2'(k % 4))); end
         @(negedge clk);
         vec_cnt++; if (obs !== ex(4'b0, 1'b0, g, 4'd0, 2'(k % 4))) begin err_cnt++; $display("FAIL rr_done%0d got %h exp %h", k, obs, ex(4'b0, 1'b0, g, 4'd0, 2'(k % 4))); end
         if (k == 4) req = '0;
         @(negedge clk);
         vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0, 4'd0, 2'(k % 4))) begin err_cnt++; $display("FAIL rr_gap%0d got %h exp %h", k, obs, ex(4'b0, 1'b0, 4'b0, 4'd0, 2'(k % 4))); end
      end
   endtask

   task automatic test_limits();
      do_reset();
      req = 4'b0100;
      limit_in[11:8] = 4'd0;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0100, 1'b1, 4'b0, 4'd0, 2'd2)) begin err_cnt++; $display("FAIL zero_run got %h exp %h", obs, ex(4'b0100, 1'b1, 4'b0, 4'd0, 2'd2)); end
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0100, 4'd0, 2'd2)) begin err_cnt++; $display("FAIL zero_done got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0100, 4'd0, 2'd2)); end
      req = '0;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd2)) begin err_cnt++; $display("FAIL zero_idle got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd2)); end
      // rr_ptr is now 3, so the search wraps 3 -> 0 to find requester 0.
      req = 4'b0001;
      limit_in[3:0] = 4'd15;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         vec_cnt++; if (obs !== ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)) begin err_cnt++; $display("FAIL max_run%0d got %h exp %h", i, obs, ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)); end
      end
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0001, 4'd0, 2'd0)) begin err_cnt++; $display("FAIL max_done got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0001, 4'd0, 2'd0)); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      do_reset();
      req = 4'b0010;
      limit_in[7:4] = 4'd10;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0010, 1'b1, 4'b0, 4'd0, 2'd1)) begin err_cnt++; $display("FAIL abort_grant got %h exp %h", obs, ex(4'b0010, 1'b1, 4'b0, 4'd0, 2'd1)); end
      req = 4'b1010;
      for (int i = 1; i < 5; i++) begin
         @(negedge clk);
         vec_cnt++; if (obs !== ex(4'b0010, 1'b1, 4'b0, 4'(i), 2'd1)) begin err_cnt++; $display("FAIL abort_run%0d got %h exp %h", i, obs, ex(4'b0010, 1'b1, 4'b0, 4'(i), 2'd1)); end
      end
      req = 4'b1000;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd1)) begin err_cnt++; $display("FAIL abort_drop got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd1)); end
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b1000, 1'b1, 4'b0, 4'd0, 2'd3)) begin err_cnt++; $display("FAIL abort_next got %h exp %h", obs, ex(4'b1000, 1'b1, 4'b0, 4'd0, 2'd3)); end
      req = '0;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd3)) begin err_cnt++; $display("FAIL abort_limitmatch got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0, 4'd0, 2'd3)); end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0001;
      limit_in[3:0] = 4'd10;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vec_cnt++; if (obs !== ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)) begin err_cnt++; $display("FAIL arst_run%0d got %h exp %h", i, obs, ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)); end
      end
      #2 reset = 1'b1;
      #1;
      vec_cnt++; if (obs !== 15'd0) begin err_cnt++; $display("FAIL arst_immediate got %h exp %h", obs, 15'd0); end
      req = 4'b1010;
      @(negedge clk);
      vec_cnt++; if (obs !== 15'd0) begin err_cnt++; $display("FAIL arst_held got %h exp %h", obs, 15'd0); end
      reset = 1'b0;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0010, 1'b1, 4'b0, 4'd0, 2'd1)) begin err_cnt++; $display("FAIL arst_first got %h exp %h", obs, ex(4'b0010, 1'b1, 4'b0, 4'd0, 2'd1)); end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_limit_change();
      do_reset();
      req = 4'b0001;
      limit_in[3:0] = 4'd7;
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0001, 1'b1, 4'b0, 4'd0, 2'd0)) begin err_cnt++; $display("FAIL limchg_run0 got %h exp %h", obs, ex(4'b0001, 1'b1, 4'b0, 4'd0, 2'd0)); end
      limit_in[3:0] = 4'd2;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         vec_cnt++; if (obs !== ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)) begin err_cnt++; $display("FAIL limchg_run%0d got %h exp %h", i, obs, ex(4'b0001, 1'b1, 4'b0, 4'(i), 2'd0)); end
      end
      @(negedge clk);
      vec_cnt++; if (obs !== ex(4'b0, 1'b0, 4'b0001, 4'd0, 2'd0)) begin err_cnt++; $display("FAIL limchg_done got %h exp %h", obs, ex(4'b0, 1'b0, 4'b0001, 4'd0, 2'd0)); end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_limits();
      test_abort();
      test_async_reset();
      test_limit_change();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
